// File: rtl/resp_pkg.sv
// Shared types and constants for the RESP grant generator.
// Define RESP_TIMEOUT_EN to add the TMO state and the grant-hold timeout.
package resp_pkg;

    localparam int RESP_GRANT_DELAY = 3;
    localparam int RESP_MAX_HOLD    = 16;
    localparam int RESP_TXN_W       = 16;
    localparam int RESP_DLY_W       = 4;
    localparam int RESP_HOLD_W      = 8;

`ifdef RESP_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2,
        TMO   = 2'd3
    } resp_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } resp_state_t;
`endif

endpackage

// File: rtl/resp_grant_gen.sv
// RESP request/grant handshake generator.
// A request held high for GRANT_DELAY edges earns a registered grant that
// stays high until the request drops; completed grants are counted.
// Define RESP_TIMEOUT_EN to limit the grant phase to MAX_HOLD request-high
// edges, flag err_timeout and park in TMO until the request drops.
module resp_grant_gen
    import resp_pkg::*;
#(
    parameter int GRANT_DELAY = RESP_GRANT_DELAY,
    parameter int MAX_HOLD    = RESP_MAX_HOLD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    output logic                  grant,
    output logic                  busy,
    output logic                  abort,
    output logic [RESP_TXN_W-1:0] txn_cnt,
    output logic                  err_timeout
);

    localparam logic [RESP_DLY_W-1:0]  DLY_LOAD  = RESP_DLY_W'(GRANT_DELAY - 1);
    localparam logic [RESP_HOLD_W-1:0] HOLD_LAST = RESP_HOLD_W'(MAX_HOLD - 1);

    // Elaboration-time guard on the legal parameter ranges.
    if (GRANT_DELAY < 1 || GRANT_DELAY > 15 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("resp_grant_gen: GRANT_DELAY or MAX_HOLD out of range");
    end

    resp_state_t           state, state_nxt;
    logic [RESP_DLY_W-1:0] dly_cnt, dly_nxt;
    logic                  grant_nxt;
    logic                  abort_nxt;
    logic                  txn_inc;

`ifdef RESP_TIMEOUT_EN
    logic [RESP_HOLD_W-1:0] hold_cnt, hold_nxt;
    logic                   tmo_hit;
`endif

    assign busy = (state != IDLE);

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        grant_nxt = 1'b0;
        abort_nxt = 1'b0;
        txn_inc   = 1'b0;
`ifdef RESP_TIMEOUT_EN
        hold_nxt  = '0;
        tmo_hit   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (request) begin
                    if (GRANT_DELAY == 1) begin
                        state_nxt = GRANT;
                        grant_nxt = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        dly_nxt   = DLY_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!request) begin
                    // Requester gave up before the grant: abort, count nothing.
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                    dly_nxt   = '0;
                end else if (dly_cnt == RESP_DLY_W'(1)) begin
                    // Grant is registered on the edge the counter hits zero.
                    state_nxt = GRANT;
                    grant_nxt = 1'b1;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly_cnt - RESP_DLY_W'(1);
                end
            end
            GRANT: begin
                if (request) begin
`ifdef RESP_TIMEOUT_EN
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = TMO;
                        tmo_hit   = 1'b1;
                    end else begin
                        grant_nxt = 1'b1;
                        hold_nxt  = hold_cnt + RESP_HOLD_W'(1);
                    end
`else
                    grant_nxt = 1'b1;
`endif
                end else begin
                    state_nxt = IDLE;
                    txn_inc   = 1'b1;
                end
            end
`ifdef RESP_TIMEOUT_EN
            TMO: begin
                if (!request) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and registered outputs; reset overrides the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dly_cnt <= '0;
            grant   <= 1'b0;
            abort   <= 1'b0;
            txn_cnt <= '0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_nxt;
            grant   <= grant_nxt;
            abort   <= abort_nxt;
            if (txn_inc) begin
                txn_cnt <= txn_cnt + RESP_TXN_W'(1);
            end
        end
    end

`ifdef RESP_TIMEOUT_EN
    // Hold counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            hold_cnt <= hold_nxt;
            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_resp_grant_gen.sv
// Self-checking bench for resp_grant_gen: fixed vector table, hand-written
// corner sequences and random request bursts against a run-length model.
module tb_resp_grant_gen;

    localparam int GD = 3;
`ifdef RESP_TIMEOUT_EN
    localparam int MH     = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int MH     = 16;
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        request = 1'b0;
    logic        grant, busy, abort, err_timeout;
    logic [15:0] txn_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: length of the current request-high run of a transaction.
    int          m_run   = 0;
    logic        m_grant = 1'b0;
    logic        m_abort = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_err   = 1'b0;
    logic [15:0] m_cnt   = 16'd0;

    typedef struct {
        logic        rst;
        logic        req;
        logic        g;
        logic        a;
        logic        b;
        logic [15:0] t;
    } vec_t;

    vec_t tbl[16];

    resp_grant_gen #(.GRANT_DELAY(GD), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .rst        (rst),
        .request    (request),
        .grant      (grant),
        .busy       (busy),
        .abort      (abort),
        .txn_cnt    (txn_cnt),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Grant is earned after GD request-high edges and, with the timeout,
    // lost after MH further request-high edges.
    task automatic model_edge(input logic r, input logic q);
        if (r) begin
            m_run = 0; m_grant = 1'b0; m_abort = 1'b0; m_cnt = 16'd0; m_err = 1'b0;
        end else if (q) begin
            m_run++;
            m_abort = 1'b0;
            m_grant = (m_run >= GD) && (!TMO_EN || m_run < GD + MH);
            if (TMO_EN && m_run == GD + MH) m_err = 1'b1;
        end else begin
            m_abort = (m_run > 0) && (m_run < GD);
            if (m_run >= GD && (!TMO_EN || m_run < GD + MH)) m_cnt = m_cnt + 16'd1;
            m_run   = 0;
            m_grant = 1'b0;
        end
        m_busy = (m_run > 0);
    endtask

    task automatic step(input logic r, input logic q);
        @(negedge clk);
        rst     = r;
        request = q;
        @(posedge clk);
        model_edge(r, q);
        #1;
        check("grant", {31'd0, grant}, {31'd0, m_grant});
        check("abort", {31'd0, abort}, {31'd0, m_abort});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("txn_cnt", {16'd0, txn_cnt}, {16'd0, m_cnt});
        check("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
        check("grant_abort_excl", {31'd0, grant & abort}, 32'd0);
    endtask

    initial begin
        // rst req | grant abort busy txn
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].req);
            check($sformatf("tbl%0d_grant", i), {31'd0, grant}, {31'd0, tbl[i].g});
            check($sformatf("tbl%0d_abort", i), {31'd0, abort}, {31'd0, tbl[i].a});
            check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].b});
            check($sformatf("tbl%0d_txn", i), {16'd0, txn_cnt}, {16'd0, tbl[i].t});
        end

        // Nominal handshake followed immediately by a second request.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("b2b_txn", {16'd0, txn_cnt}, 32'd2);

        // Long hold: timeout build drops grant and flags, default keeps grant.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        check("long_hold_grant", {31'd0, grant}, {31'd0, ~TMO_EN});
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("err_sticky", {31'd0, err_timeout}, {31'd0, TMO_EN});
        check("long_hold_txn", {16'd0, txn_cnt}, TMO_EN ? 32'd2 : 32'd3);

        // Counter wrap from a preloaded value.
        @(negedge clk);
        force dut.txn_cnt = 16'hFFFE;
        #1;
        release dut.txn_cnt;
        m_cnt = 16'hFFFE;
        #1;
        check("preload", {16'd0, txn_cnt}, 32'h0000FFFE);
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        check("wrap", {16'd0, txn_cnt}, 32'd0);

        // Random request bursts with occasional reset.
        for (int b = 0; b < 80; b++) begin
            int hi;
            int lo;
            hi = $urandom_range(0, 9);
            lo = $urandom_range(1, 3);
            for (int i = 0; i < hi; i++) step(($urandom_range(0, 59) == 0), 1'b1);
            for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
